// File: rtl/gf2m_mult_sequencer.sv
// Operand-side controller for a bit-parallel systolic GF(2^m) multiplier array.
// Accepts one (A, B) pair, feeds B MSB-first for M cycles, then returns the array's c vector.
module gf2m_mult_sequencer #(
  parameter int           M      = 8,
  parameter logic [M-1:0] F_POLY = 8'h1B
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_c,
  output logic         busy,
  output logic         arr_clr,
  output logic         arr_sel,
  output logic         arr_b,
  output logic [M-1:0] arr_a,
  output logic [M-1:0] arr_f,
  input  logic [M-1:0] arr_c
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_FEED = 3'd2,
    S_CAPT = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  a_q, a_d;
  logic [M-1:0]  b_q, b_d;
  logic [M-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every register takes its reset value here, so an abort mid-feed can never leak a partial product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    arr_clr   = 1'b0;
    arr_sel   = 1'b0;
    arr_b     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        arr_clr = 1'b1;
        cnt_d   = CNT_TOP;
        state_d = S_FEED;
      end
      S_FEED: begin
        // The PE array latches A only on the first feed cycle and recirculates it afterwards.
        arr_b   = b_q[cnt_q];
        arr_sel = (cnt_q == CNT_TOP);
        if (cnt_q == '0) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPT: begin
        c_d     = arr_c;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign out_c = c_q;
  assign arr_a = a_q;
  assign arr_f = F_POLY;

endmodule

// File: tb/tb_gf2m_mult_sequencer.sv
// Bench for gf2m_mult_sequencer: behavioural MSB-first array model on arr_*,
// results checked against an LSB-first shift-and-add GF(2^8) multiply.
module tb_gf2m_mult_sequencer;

  localparam int         M = 8;
  localparam logic [7:0] F = 8'h1B;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic       arr_clr, arr_sel, arr_b;
  logic [7:0] in_a, in_b, out_c, arr_a, arr_f;
  logic [7:0] arr_c_m = '0;
  logic [7:0] pe_a    = '0;
  int         cyc     = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gf2m_mult_sequencer #(.M(M), .F_POLY(F)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy),
    .arr_clr(arr_clr), .arr_sel(arr_sel), .arr_b(arr_b),
    .arr_a(arr_a), .arr_f(arr_f), .arr_c(arr_c_m)
  );

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? F : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] pe_a_eff(input logic sel, input logic [7:0] a_in, input logic [7:0] a_reg);
    return sel ? a_in : a_reg;
  endfunction

  // Systolic array stand-in: Horner step c = c*x + b*A on every edge, cleared by arr_clr.
  always @(posedge clk) begin
    pe_a <= pe_a_eff(arr_sel, arr_a, pe_a);
    if (arr_clr) arr_c_m <= '0;
    else         arr_c_m <= xtime(arr_c_m) ^ (arr_b ? pe_a_eff(arr_sel, arr_a, pe_a) : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, out_valid, 1);
  endtask

  task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input string tag,
                         output logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid(tag);
    c = out_c;
    check({tag, "_model"}, out_c, gf_mul(a, b));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_c"}, out_c, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_arr_clr"}, arr_clr, 0);
    check({tag, "_arr_sel"}, arr_sel, 0);
    check({tag, "_arr_b"}, arr_b, 0);
    check({tag, "_arr_a"}, arr_a, 0);
  endtask

  logic [7:0] dir_a [5] = '{8'h57, 8'h57, 8'h00, 8'hFF, 8'hA5};
  logic [7:0] dir_b [5] = '{8'h83, 8'h13, 8'hFF, 8'h00, 8'h01};
  logic [7:0] dir_c [5] = '{8'hC1, 8'hFE, 8'h00, 8'h00, 8'hA5};

  initial begin
    logic [7:0] res, bv, xa, xb;
    int         t_prev, t_now, n;

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    check("arr_f", arr_f, 8'h1B);
    reset = 1'b1;

    // out_ready with nothing pending must not disturb IDLE
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_oready_busy", busy, 0);
    check("idle_oready_vld", out_valid, 0);

    for (int i = 0; i < 5; i++) begin
      do_mult(dir_a[i], dir_b[i], $sformatf("dir%0d", i), res);
      check($sformatf("dir%0d_const", i), res, dir_c[i]);
    end

    // Cycle-by-cycle array drive for A=0x57, B=0x83
    bv = 8'h83;
    @(negedge clk);
    check("lat_idle_rdy", in_ready, 1);
    in_valid = 1'b1; in_a = 8'h57; in_b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_clr", arr_clr, 1);
    check("lat_clr_sel", arr_sel, 0);
    check("lat_clr_b", arr_b, 0);
    check("lat_clr_rdy", in_ready, 0);
    check("lat_clr_busy", busy, 1);
    check("lat_arr_a", arr_a, 8'h57);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("feed%0d_clr", k), arr_clr, 0);
      check($sformatf("feed%0d_sel", k), arr_sel, (k == 0) ? 1 : 0);
      check($sformatf("feed%0d_b", k), arr_b, bv[7-k]);
      check($sformatf("feed%0d_rdy", k), in_ready, 0);
      check($sformatf("feed%0d_vld", k), out_valid, 0);
    end
    @(negedge clk);
    check("capt_vld", out_valid, 0);
    check("capt_sel", arr_sel, 0);
    @(negedge clk);
    check("hold_vld", out_valid, 1);
    check("hold_c", out_c, 8'hC1);

    // Backpressure: 20 cycles of out_ready=0 with stray in_valid pulses
    for (int k = 0; k < 20; k++) begin
      in_valid = (k % 3 == 0);
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(negedge clk);
      check($sformatf("bp%0d_vld", k), out_valid, 1);
      check($sformatf("bp%0d_c", k), out_c, 8'hC1);
      check($sformatf("bp%0d_rdy", k), in_ready, 0);
      check($sformatf("bp%0d_clr", k), arr_clr, 0);
    end

    // Release with in_valid high: the consume cycle must not accept
    xa = 8'($urandom); xb = 8'($urandom);
    in_valid = 1'b1; in_a = xa; in_b = xb; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_vld", out_valid, 0);
    check("rel_busy", busy, 0);
    check("rel_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("rel_next_clr", arr_clr, 1);
    check("rel_next_a", arr_a, xa);
    wait_out_valid("rel_next");
    check("rel_next_c", out_c, gf_mul(xa, xb));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_idle", busy, 0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b%0d_rdy", i), in_ready, 1);
      xa = 8'($urandom); xb = 8'($urandom);
      in_valid = 1'b1; in_a = xa; in_b = xb;
      t_now = cyc;
      if (i > 0) check($sformatf("b2b%0d_interval", i), t_now - t_prev, 12);
      t_prev = t_now;
      @(negedge clk);
      wait_out_valid($sformatf("b2b%0d", i));
      check($sformatf("b2b%0d_c", i), out_c, gf_mul(xa, xb));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Reset during FEED at cnt=3
    @(negedge clk);
    bv = 8'h3C;
    in_valid = 1'b1; in_a = 8'h5A; in_b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_b3", arr_b, bv[3]);
    check("mid_sel", arr_sel, 0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    check("mid_rst_hold_busy", busy, 0);
    reset = 1'b1;
    do_mult(8'h57, 8'h83, "post_rst", res);
    check("post_rst_const", res, 8'hC1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
